// File: rtl/line_ser_pkg.sv
// Shared types and width helper for the line-to-chunk serializer.
package line_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // Index/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_chunk_serializer.sv
// Buffers one wide line and emits it as CHUNKS chunks of CHUNK_W bits, tagging
// each chunk with its index, the line's row in the frame and sol/eol/eof markers.
module line_chunk_serializer
  import line_ser_pkg::*;
#(
  parameter int CHUNK_W   = 16,
  parameter int CHUNKS    = 30,
  parameter int ROWS      = 480,
  parameter bit MSB_FIRST = 1'b0,
  localparam int LINE_W   = CHUNK_W * CHUNKS,
  localparam int IDX_W    = clog2_min1(CHUNKS),
  localparam int ROW_W    = clog2_min1(ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_restart,
  input  logic              line_valid,
  output logic              line_ready,
  input  logic [LINE_W-1:0] line_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHUNK_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_chunk,
  output logic [ROW_W-1:0]  out_row,
  output logic              out_sol,
  output logic              out_eol,
  output logic              out_eof
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  ser_state_e         state_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [LINE_W-1:0]  buf_q;
  logic [IDX_W-1:0]   sel_idx;
  logic [CHUNK_W-1:0] chunk;
  logic               last_hs;
  logic               line_hs;

  // Both ports use valid/ready: a transfer happens on a rising edge where valid
  // and ready are both high; valid side holds its payload stable until then.
  assign out_valid  = (state_q == SEND);
  assign out_chunk  = idx_q;
  assign out_row    = row_q;
  assign out_sol    = out_valid && (idx_q == '0);
  assign out_eol    = out_valid && (idx_q == LAST_IDX);
  assign out_eof    = out_eol && (row_q == LAST_ROW);
  assign last_hs    = out_eol && out_ready;
  // A new line may be taken while the previous line's last chunk leaves.
  assign line_ready = rst_n && !frame_restart && ((state_q == IDLE) || last_hs);
  assign line_hs    = line_valid && line_ready;

  always_comb begin
    idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
  end

  always_comb begin
    sel_idx = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;
    chunk   = '0;
    if (int'(sel_idx) < CHUNKS) chunk = buf_q[int'(sel_idx)*CHUNK_W +: CHUNK_W];
  end

  assign out_data = out_valid ? chunk : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      row_q   <= '0;
      buf_q   <= '0;
    end else if (frame_restart) begin
      state_q <= IDLE;
      idx_q   <= '0;
      row_q   <= '0;
      buf_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (line_hs) begin
            buf_q   <= line_data;
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            idx_q <= idx_d;
            if (idx_q == LAST_IDX) begin
              row_q <= row_d;
              if (line_hs) buf_q <= line_data;
              else state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_chunk_serializer.sv
// Randomised bench for line_chunk_serializer against a queue-based reference model.
module tb_line_chunk_serializer;

  localparam int CW = 16;
  localparam int CN = 30;
  localparam int RW = 480;
  localparam int LW = CW * CN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic          frame_restart = 1'b0, line_valid = 1'b0, out_ready = 1'b0;
  logic [LW-1:0] line_data = '0;
  logic          line_ready, out_valid, out_sol, out_eol, out_eof;
  logic [CW-1:0] out_data;
  logic [4:0]    out_chunk;
  logic [8:0]    out_row;

  // MSB_FIRST instance
  logic          b_line_valid = 1'b0;
  logic [LW-1:0] b_line_data = '0;
  logic          b_line_ready, b_out_valid, b_out_sol, b_out_eol, b_out_eof;
  logic [CW-1:0] b_out_data;
  logic [4:0]    b_out_chunk;
  logic [8:0]    b_out_row;

  // single-chunk instance
  logic       c_line_valid = 1'b0;
  logic [7:0] c_line_data = '0;
  logic       c_line_ready, c_out_valid, c_out_sol, c_out_eol, c_out_eof;
  logic [7:0] c_out_data;
  logic [0:0] c_out_chunk;
  logic [1:0] c_out_row;

  line_chunk_serializer dut (
    .clk(clk), .rst_n(rst_n), .frame_restart(frame_restart),
    .line_valid(line_valid), .line_ready(line_ready), .line_data(line_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chunk(out_chunk), .out_row(out_row), .out_sol(out_sol),
    .out_eol(out_eol), .out_eof(out_eof)
  );

  line_chunk_serializer #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .frame_restart(1'b0),
    .line_valid(b_line_valid), .line_ready(b_line_ready), .line_data(b_line_data),
    .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data),
    .out_chunk(b_out_chunk), .out_row(b_out_row), .out_sol(b_out_sol),
    .out_eol(b_out_eol), .out_eof(b_out_eof)
  );

  line_chunk_serializer #(.CHUNK_W(8), .CHUNKS(1), .ROWS(3)) dut_one (
    .clk(clk), .rst_n(rst_n), .frame_restart(1'b0),
    .line_valid(c_line_valid), .line_ready(c_line_ready), .line_data(c_line_data),
    .out_valid(c_out_valid), .out_ready(1'b1), .out_data(c_out_data),
    .out_chunk(c_out_chunk), .out_row(c_out_row), .out_sol(c_out_sol),
    .out_eol(c_out_eol), .out_eof(c_out_eof)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: chunks still owed to the sink, and the row being sent.
  logic [CW-1:0] exp_q[$];
  int            exp_row = 0;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic exp_ready();
    return !frame_restart && (exp_q.size() == 0 || (exp_q.size() == 1 && out_ready));
  endfunction

  // Apply the current inputs to the model, then step the clock.
  task automatic advance();
    if (frame_restart) begin
      exp_q.delete();
      exp_row = 0;
    end else begin
      if (exp_q.size() != 0 && out_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) exp_row = (exp_row + 1) % RW;
      end
      if (line_valid && exp_q.size() == 0)
        for (int i = 0; i < CN; i++) exp_q.push_back(line_data[i*CW +: CW]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic restart_pulse();
    frame_restart = 1'b1;
    line_valid = 1'b0;
    advance();
    frame_restart = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_sol, out_eol, out_eof, line_ready} !== 5'b0 || out_data !== '0) begin
        failures++;
        $display("FAIL reset_outputs got v=%b sol=%b eol=%b eof=%b rdy=%b data=%h required all 0",
                 out_valid, out_sol, out_eol, out_eof, line_ready, out_data);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (line_ready !== 1'b1 || out_row !== 9'd0 || out_chunk !== 5'd0) begin
      failures++;
      $display("FAIL reset_release got rdy=%b row=%0d chunk=%0d required rdy=1 row=0 chunk=0",
               line_ready, out_row, out_chunk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_line();
    logic [LW-1:0] l;
    int xfers = 0;
    for (int i = 0; i < CN; i++) l[i*CW +: CW] = CW'(i);
    line_data = l;
    line_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      logic hs;
      @(negedge clk);
      checks++;
      if (line_ready !== exp_ready() || out_valid !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL single_hs cyc=%0d got rdy=%b v=%b required rdy=%b v=%b",
                 cyc, line_ready, out_valid, exp_ready(), exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if (out_data !== exp_q[0] || out_chunk !== 5'(CN - exp_q.size()) ||
            out_sol !== (exp_q.size() == CN) || out_eol !== (exp_q.size() == 1)) begin
          failures++;
          $display("FAIL single_chunk cyc=%0d got data=%h idx=%0d sol=%b eol=%b required data=%h idx=%0d",
                   cyc, out_data, out_chunk, out_sol, out_eol, exp_q[0], CN - exp_q.size());
        end
      end
      if (out_valid && out_ready) xfers++;
      hs = line_valid && exp_ready();
      advance();
      if (hs) line_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (xfers != CN || out_valid !== 1'b0 || line_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_end got xfers=%0d v=%b rdy=%b required xfers=%0d v=0 rdy=1",
               xfers, out_valid, line_ready, CN);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    int xfers = 0;
    logic prev_stall = 1'b0;
    logic [CW-1:0] prev_data = '0;
    logic [4:0] prev_chunk = '0;
    logic sent = 1'b0;
    line_data = rand_line();
    line_valid = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic hs;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (exp_q.size() != 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_q[0] || out_chunk !== 5'(CN - exp_q.size())) begin
          failures++;
          $display("FAIL stall_data cyc=%0d got v=%b data=%h idx=%0d required v=1 data=%h idx=%0d",
                   cyc, out_valid, out_data, out_chunk, exp_q[0], CN - exp_q.size());
        end
      end
      if (prev_stall) begin
        checks++;
        if (out_data !== prev_data || out_chunk !== prev_chunk) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got data=%h idx=%0d required data=%h idx=%0d",
                   cyc, out_data, out_chunk, prev_data, prev_chunk);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_chunk = out_chunk;
      if (out_valid && out_ready) xfers++;
      hs = line_valid && exp_ready();
      advance();
      if (hs) begin
        line_valid = 1'b0;
        sent = 1'b1;
      end
      if (sent && exp_q.size() == 0) break;
    end
    checks++;
    if (xfers != CN || exp_q.size() != 0) begin
      failures++;
      $display("FAIL stall_count got xfers=%0d pending=%0d required xfers=%0d pending=0",
               xfers, exp_q.size(), CN);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    int lines = 0, xfers = 0, run = 0;
    int rows_seen[$];
    logic started = 1'b0;
    restart_pulse();
    out_ready = 1'b1;
    line_valid = 1'b1;
    line_data = rand_line();
    for (int cyc = 0; cyc < 200; cyc++) begin
      logic hs;
      @(negedge clk);
      checks++;
      if (line_ready !== exp_ready() || out_valid !== (exp_q.size() != 0) ||
          (exp_q.size() != 0 && (out_data !== exp_q[0] || out_row !== 9'(exp_row)))) begin
        failures++;
        $display("FAIL b2b_cycle cyc=%0d got rdy=%b v=%b data=%h row=%0d required rdy=%b v=%b row=%0d",
                 cyc, line_ready, out_valid, out_data, out_row, exp_ready(), exp_q.size() != 0, exp_row);
      end
      if (out_valid) started = 1'b1;
      if (started && xfers < 3 * CN) run++;
      if (out_sol) rows_seen.push_back(int'(out_row));
      if (out_valid && out_ready) xfers++;
      hs = line_valid && exp_ready();
      advance();
      if (hs) begin
        lines++;
        line_data = rand_line();
        if (lines == 3) line_valid = 1'b0;
      end
      if (lines == 3 && exp_q.size() == 0) break;
    end
    checks++;
    if (xfers != 3 * CN || run != 3 * CN || rows_seen.size() != 3) begin
      failures++;
      $display("FAIL b2b_bubble got xfers=%0d valid_run=%0d lines_seen=%0d required %0d %0d 3",
               xfers, run, rows_seen.size(), 3 * CN, 3 * CN);
    end else begin
      checks++;
      if (rows_seen[0] != 0 || rows_seen[1] != 1 || rows_seen[2] != 2) begin
        failures++;
        $display("FAIL b2b_rows got %0d,%0d,%0d required 0,1,2", rows_seen[0], rows_seen[1], rows_seen[2]);
      end
    end
  endtask

  task automatic test_full_frame();
    int lines = 0, eof_cnt = 0, eof_row = -1, eof_idx = -1, row_after = -1;
    logic after_eof = 1'b0;
    restart_pulse();
    out_ready = 1'b1;
    line_valid = 1'b1;
    line_data = rand_line();
    for (int cyc = 0; cyc < (RW + 2) * CN; cyc++) begin
      logic hs;
      @(negedge clk);
      checks++;
      if (out_valid !== (exp_q.size() != 0) ||
          (exp_q.size() != 0 && (out_data !== exp_q[0] || out_row !== 9'(exp_row) ||
           out_eof !== (exp_q.size() == 1 && exp_row == RW - 1)))) begin
        failures++;
        $display("FAIL frame_cycle cyc=%0d got v=%b data=%h row=%0d eof=%b required row=%0d",
                 cyc, out_valid, out_data, out_row, out_eof, exp_row);
      end
      if (out_eof) begin
        eof_cnt++;
        eof_row = int'(out_row);
        eof_idx = int'(out_chunk);
        after_eof = 1'b1;
      end else if (after_eof && out_sol && row_after < 0) begin
        row_after = int'(out_row);
      end
      hs = line_valid && exp_ready();
      advance();
      if (hs) begin
        lines++;
        line_data = rand_line();
        if (lines == RW + 1) line_valid = 1'b0;
      end
      if (lines == RW + 1 && exp_q.size() == 0) break;
    end
    checks++;
    if (eof_cnt != 1 || eof_row != RW - 1 || eof_idx != CN - 1 || row_after != 0) begin
      failures++;
      $display("FAIL frame_eof got count=%0d row=%0d idx=%0d next_row=%0d required 1 %0d %0d 0",
               eof_cnt, eof_row, eof_idx, row_after, RW - 1, CN - 1);
    end
  endtask

  task automatic test_frame_restart();
    logic [LW-1:0] l;
    logic hit = 1'b0;
    restart_pulse();
    out_ready = 1'b1;
    line_valid = 1'b1;
    line_data = rand_line();
    for (int cyc = 0; cyc < 8 * CN; cyc++) begin
      logic hs;
      @(negedge clk);
      if (exp_row == 5 && CN - exp_q.size() == 10) begin
        hit = 1'b1;
        break;
      end
      hs = line_valid && exp_ready();
      advance();
      if (hs) line_data = rand_line();
    end
    checks++;
    if (!hit || out_row !== 9'd5 || out_chunk !== 5'd10) begin
      failures++;
      $display("FAIL restart_reach got reached=%b row=%0d idx=%0d required reached=1 row=5 idx=10",
               hit, out_row, out_chunk);
    end
    @(posedge clk);
    #1 frame_restart = 1'b1;
    @(negedge clk);
    checks++;
    if (line_ready !== 1'b0) begin
      failures++;
      $display("FAIL restart_ready got rdy=%b required 0", line_ready);
    end
    advance();
    frame_restart = 1'b0;
    l = rand_line();
    line_data = l;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL restart_valid got v=%b required 0", out_valid);
    end
    advance();
    line_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_row !== 9'd0 || out_chunk !== 5'd0 || out_sol !== 1'b1 ||
        out_data !== l[CW-1:0]) begin
      failures++;
      $display("FAIL restart_next got v=%b row=%0d idx=%0d sol=%b data=%h required 1 0 0 1 %h",
               out_valid, out_row, out_chunk, out_sol, out_data, l[CW-1:0]);
    end
    for (int cyc = 0; cyc < CN + 2; cyc++) begin
      if (exp_q.size() == 0) break;
      advance();
    end
  endtask

  task automatic test_reset_mid_line();
    line_data = rand_line();
    line_valid = 1'b1;
    out_ready = 1'b1;
    advance();
    line_valid = 1'b0;
    repeat (5) advance();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    exp_row = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_eol !== 1'b0 || line_ready !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL midreset_now got v=%b eol=%b rdy=%b data=%h required 0 0 0 0",
               out_valid, out_eol, line_ready, out_data);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || line_ready !== 1'b1) begin
        failures++;
        $display("FAIL midreset_after cyc=%0d got v=%b rdy=%b required v=0 rdy=1", cyc, out_valid, line_ready);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_msb_first();
    logic [LW-1:0] l;
    for (int n = 0; n < 2; n++) begin
      l = (n == 0) ? {16'hAAAA, {(LW - CW){1'b0}}} : rand_line();
      b_line_data = l;
      b_line_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (b_line_ready !== 1'b1) begin
        failures++;
        $display("FAIL msb_ready line=%0d got %b required 1", n, b_line_ready);
      end
      @(posedge clk);
      #1 b_line_valid = 1'b0;
      for (int i = 0; i < CN; i++) begin
        @(negedge clk);
        checks++;
        if (b_out_valid !== 1'b1 || b_out_chunk !== 5'(i) || b_out_data !== l[(CN-1-i)*CW +: CW]) begin
          failures++;
          $display("FAIL msb_chunk line=%0d i=%0d got v=%b idx=%0d data=%h required v=1 data=%h",
                   n, i, b_out_valid, b_out_chunk, b_out_data, l[(CN-1-i)*CW +: CW]);
        end
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      checks++;
      if (b_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL msb_idle line=%0d got v=%b required 0", n, b_out_valid);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_single_chunk();
    logic [7:0] vals[6];
    foreach (vals[k]) vals[k] = 8'($urandom);
    c_line_data = vals[0];
    c_line_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (k < 5) c_line_data = vals[k+1];
      else c_line_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (c_out_valid !== 1'b1 || c_out_data !== vals[k] || c_out_sol !== 1'b1 || c_out_eol !== 1'b1 ||
          c_out_row !== 2'(k % 3) || c_out_eof !== (k % 3 == 2)) begin
        failures++;
        $display("FAIL one_chunk k=%0d got v=%b data=%h sol=%b eol=%b row=%0d eof=%b required data=%h row=%0d",
                 k, c_out_valid, c_out_data, c_out_sol, c_out_eol, c_out_row, c_out_eof, vals[k], k % 3);
      end
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (c_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL one_chunk_idle got v=%b required 0", c_out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_stall();
    test_back_to_back();
    test_full_frame();
    test_frame_restart();
    test_msb_first();
    test_single_chunk();
    test_reset_mid_line();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
